// File: rtl/subtractor_serial.sv
// Multi-cycle ripple-borrow subtractor: d = a - b - bin, DIGIT bits per RUN cycle.
// Optional signed-overflow output enabled by defining SUBTRACTOR_SERIAL_OVF_EN.
module subtractor_serial #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
`ifdef SUBTRACTOR_SERIAL_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both high;
    // valid must hold its data until that edge, ready never depends combinationally on valid.

    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] d_q;
    logic             borrow_q;
    logic             bout_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT:0]   dig_d;
    logic [WIDTH-1:0] d_shift_d;
    logic             last_step_d;

    // The extra top bit of the digit difference goes negative exactly when a borrow is needed.
    assign dig_d       = {1'b0, a_q[DIGIT-1:0]} - {1'b0, b_q[DIGIT-1:0]} - {{DIGIT{1'b0}}, borrow_q};
    assign last_step_d = (cnt_q == CW'(STEPS - 1));

    generate
        if (DIGIT == WIDTH) begin : g_full
            assign d_shift_d = dig_d[DIGIT-1:0];
        end else begin : g_shift
            assign d_shift_d = {dig_d[DIGIT-1:0], d_q[WIDTH-1:DIGIT]};
        end
    endgenerate

`ifdef SUBTRACTOR_SERIAL_OVF_EN
    logic ovf_q;
    logic ovf_d;
    // On the last step the low digit of a_q/b_q holds the operand MSBs.
    assign ovf_d = (a_q[DIGIT-1] != b_q[DIGIT-1]) && (dig_d[DIGIT-1] != a_q[DIGIT-1]);
    assign ovf   = ovf_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            d_q         <= '0;
            borrow_q    <= 1'b0;
            bout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
`ifdef SUBTRACTOR_SERIAL_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        borrow_q   <= bin;
                        cnt_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= RUN;
                    end
                end
                RUN: begin
                    d_q      <= d_shift_d;
                    borrow_q <= dig_d[DIGIT];
                    a_q      <= a_q >> DIGIT;
                    b_q      <= b_q >> DIGIT;
                    if (last_step_d) begin
                        cnt_q       <= '0;
                        bout_q      <= dig_d[DIGIT];
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
`ifdef SUBTRACTOR_SERIAL_OVF_EN
                        ovf_q       <= ovf_d;
`endif
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign d         = d_q;
    assign bout      = bout_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_subtractor_serial.sv
// Bench for subtractor_serial: four instances (DIGIT = 1,2,4,8), directed cases then a random sweep.
// Define SUBTRACTOR_SERIAL_OVF_EN to also check the overflow output.
module tb_subtractor_serial;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic       iv[N];
    logic [7:0] av[N];
    logic [7:0] bv[N];
    logic       biv[N];
    logic       ordy[N];
    logic       irdy[N];
    logic       ov[N];
    logic [7:0] dv[N];
    logic       bov[N];
    logic [1:0] st[N];
`ifdef SUBTRACTOR_SERIAL_OVF_EN
    logic       ovfv[N];
`endif

    int n_cmp = 0;
    int n_err = 0;

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            subtractor_serial #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
                .clk       (clk),
                .rst_n     (rst_n),
                .in_valid  (iv[g]),
                .in_ready  (irdy[g]),
                .a         (av[g]),
                .b         (bv[g]),
                .bin       (biv[g]),
                .out_valid (ov[g]),
                .out_ready (ordy[g]),
                .d         (dv[g]),
                .bout      (bov[g]),
`ifdef SUBTRACTOR_SERIAL_OVF_EN
                .ovf       (ovfv[g]),
`endif
                .dbg_state (st[g])
            );
        end
    endgenerate

    // Reference: {ovf, bout, d} from plain unsigned and signed integer arithmetic.
    function automatic logic [9:0] model(input logic [7:0] a_v, input logic [7:0] b_v, input logic bi);
        int ua;
        int ub;
        int r;
        int sr;
        logic [7:0] dd;
        ua = int'(a_v);
        ub = int'(b_v);
        r  = ua - ub - int'(bi);
        sr = int'($signed(a_v)) - int'($signed(b_v)) - int'(bi);
        dd = r[7:0];
        return {((sr < -128) || (sr > 127)), (r < 0), dd};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Presents one operand set and returns just after the accepting edge.
    task automatic send(input int k, input logic [7:0] a_v, input logic [7:0] b_v, input logic bi);
        int t;
        t = 0;
        av[k] = a_v;
        bv[k] = b_v;
        biv[k] = bi;
        iv[k] = 1'b1;
        while (!irdy[k] && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("accept_timeout", 32'(t < 50), 32'd1);
        @(posedge clk); #1;
        iv[k] = 1'b0;
    endtask

    // Waits for out_valid and checks latency counted from the accepting edge.
    task automatic recv(input int k, output logic [9:0] res);
        int lat;
        lat = 1;
        while (!ov[k] && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("latency_k%0d", k), 32'(lat), 32'((8 >> k) + 1));
        res = {1'b0, bov[k], dv[k]};
`ifdef SUBTRACTOR_SERIAL_OVF_EN
        res[9] = ovfv[k];
`endif
    endtask

    task automatic sweep(input int k, input int n);
        logic [9:0] exp_q[$];
        logic [9:0] e;
        logic [9:0] obs;
        logic hs_in;
        logic hs_out;
        int sent;
        int got;
        int lat;
        int cyc;
        bit counting;
        sent = 0;
        got = 0;
        lat = 0;
        cyc = 0;
        counting = 1'b0;
        av[k] = 8'($urandom);
        bv[k] = 8'($urandom);
        biv[k] = 1'($urandom_range(0, 1));
        iv[k] = 1'b1;
        while (got < n && cyc < 40000) begin
            hs_in  = iv[k] && irdy[k];
            hs_out = ov[k] && ordy[k];
            obs = {1'b0, bov[k], dv[k]};
`ifdef SUBTRACTOR_SERIAL_OVF_EN
            obs[9] = ovfv[k];
`endif
            if (hs_in) exp_q.push_back(model(av[k], bv[k], biv[k]));
            @(posedge clk); #1;
            cyc++;
            if (counting) lat++;
            if (hs_in) begin
                counting = 1'b1;
                lat = 1;
                sent++;
                if (sent < n) begin
                    av[k] = 8'($urandom);
                    bv[k] = 8'($urandom);
                    biv[k] = 1'($urandom_range(0, 1));
                end else begin
                    iv[k] = 1'b0;
                end
            end
            if (hs_out) begin
                got++;
                if (exp_q.size() == 0) begin
                    check($sformatf("sweep_unexpected_k%0d", k), 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
`ifndef SUBTRACTOR_SERIAL_OVF_EN
                    e[9] = 1'b0;
`endif
                    check($sformatf("sweep_result_k%0d", k), 32'(obs), 32'(e));
                end
            end
            if (counting && ov[k]) begin
                check($sformatf("sweep_latency_k%0d", k), 32'(lat), 32'((8 >> k) + 1));
                counting = 1'b0;
            end
            ordy[k] = ($urandom_range(0, 3) != 0);
        end
        check($sformatf("sweep_count_k%0d", k), 32'(got), 32'(n));
        ordy[k] = 1'b1;
    endtask

    logic [7:0] ta[3];
    logic [7:0] tb[3];
    logic       tbi[3];
    logic [7:0] td[3];
    logic       tbo[3];
    logic       tovf[3];
    logic [9:0] res;
    int seen;

    initial begin
        ta = '{8'h00, 8'h5A, 8'h80};
        tb = '{8'h01, 8'h3C, 8'h01};
        tbi = '{1'b0, 1'b1, 1'b0};
        td = '{8'hFF, 8'h1D, 8'h7F};
        tbo = '{1'b1, 1'b0, 1'b0};
        tovf = '{1'b0, 1'b0, 1'b1};
        for (int k = 0; k < N; k++) begin
            iv[k] = 1'b0;
            av[k] = '0;
            bv[k] = '0;
            biv[k] = 1'b0;
            ordy[k] = 1'b1;
        end

        // Clock/reset
        #2 rst_n = 1'b0;
        #20;
        for (int k = 0; k < N; k++) begin
            check($sformatf("rst_in_ready_k%0d", k), 32'(irdy[k]), 32'd1);
            check($sformatf("rst_out_valid_k%0d", k), 32'(ov[k]), 32'd0);
            check($sformatf("rst_d_k%0d", k), 32'(dv[k]), 32'd0);
            check($sformatf("rst_bout_k%0d", k), 32'(bov[k]), 32'd0);
        end
        #1 rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed vectors on every DIGIT variant
        for (int k = 0; k < N; k++) begin
            for (int v = 0; v < 3; v++) begin
                send(k, ta[v], tb[v], tbi[v]);
                recv(k, res);
                check($sformatf("dir_d_k%0d_v%0d", k, v), 32'(res[7:0]), 32'(td[v]));
                check($sformatf("dir_bout_k%0d_v%0d", k, v), 32'(res[8]), 32'(tbo[v]));
`ifdef SUBTRACTOR_SERIAL_OVF_EN
                check($sformatf("dir_ovf_k%0d_v%0d", k, v), 32'(res[9]), 32'(tovf[v]));
`endif
                @(posedge clk); #1;
                check($sformatf("dir_release_k%0d_v%0d", k, v), 32'({ov[k], irdy[k]}), 32'b01);
            end
        end

        // Backpressure: result held for 5 cycles, then a single handshake
        ordy[0] = 1'b0;
        send(0, 8'hC3, 8'h42, 1'b0);
        recv(0, res);
        check("bp_d", 32'(res[7:0]), 32'h81);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check($sformatf("bp_hold_d_c%0d", c), 32'(dv[0]), 32'h81);
            check($sformatf("bp_hold_flags_c%0d", c), 32'({ov[0], irdy[0], bov[0]}), 32'b100);
        end
        ordy[0] = 1'b1;
        @(posedge clk); #1;
        check("bp_release", 32'({ov[0], irdy[0]}), 32'b01);

        // Reset while holding a result in DONE
        ordy[1] = 1'b0;
        send(1, 8'h5A, 8'h3C, 1'b1);
        recv(1, res);
        #3 rst_n = 1'b0;
        #1;
        check("rst_done_out_valid", 32'(ov[1]), 32'd0);
        check("rst_done_d", 32'(dv[1]), 32'd0);
        check("rst_done_in_ready", 32'(irdy[1]), 32'd1);
        #2 rst_n = 1'b1;
        ordy[1] = 1'b1;
        @(posedge clk); #1;

        // Reset in RUN cycle 3, then the in-flight result must never appear
        send(0, 8'hFF, 8'h0F, 1'b0);
        repeat (2) begin
            @(posedge clk); #1;
        end
        check("run_busy", 32'(irdy[0]), 32'd0);
        #3 rst_n = 1'b0;
        #1;
        check("rst_run_in_ready", 32'(irdy[0]), 32'd1);
        check("rst_run_out", 32'({ov[0], bov[0], dv[0]}), 32'd0);
        #2 rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (ov[0]) seen++;
        end
        check("rst_run_discard", 32'(seen), 32'd0);
        send(0, 8'h10, 8'h10, 1'b0);
        recv(0, res);
        check("post_rst_result", 32'(res[8:0]), 32'd0);
        @(posedge clk); #1;

        // Random sweep, back-to-back in_valid, all DIGIT variants in parallel
        fork
            sweep(0, 1000);
            sweep(1, 1000);
            sweep(2, 1000);
            sweep(3, 1000);
        join

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
